// File: rtl/clip_controller.sv
// Sequencing core of the clip recorder: turns synchronized button pulses into
// sample-rate record/playback accesses on a two-clip memory.
module clip_controller #(
    parameter int ADDR_W   = 10,
    parameter int TICK_DIV = 3125
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              resetButtonSync,
    input  logic              PlaySync,
    input  logic              RecordSync,
    input  logic              ClipNumPlaySync,
    input  logic              ClipNumRecordSync,
    input  logic [7:0]        micSample,
    output logic [ADDR_W:0]   memAddr,
    output logic              memWe,
    output logic              memRe,
    output logic [7:0]        memWData,
    input  logic [7:0]        memRData,
    output logic [7:0]        speakerSample,
    output logic              speakerValid,
    output logic              playClip,
    output logic              recordClip,
    output logic [1:0]        clipValid,
    output logic              busy
);

    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } stateT;

    stateT              stateReg, stateNext;
    logic [TICK_W-1:0]  tickReg, tickNext;
    logic [ADDR_W-1:0]  addrReg, addrNext;
    logic               activeClipReg, activeClipNext;
    logic               playClipReg, playClipNext;
    logic               recordClipReg, recordClipNext;
    logic [1:0]         clipValidReg, clipValidNext;
    logic               rdPendReg;
    logic [7:0]         heldSampleReg;
    logic               lastAddr;

    assign lastAddr = (addrReg == {ADDR_W{1'b1}});

    // Control state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg      <= IDLE;
            tickReg       <= '0;
            addrReg       <= '0;
            activeClipReg <= 1'b0;
            playClipReg   <= 1'b0;
            recordClipReg <= 1'b0;
            clipValidReg  <= 2'b00;
        end else begin
            stateReg      <= stateNext;
            tickReg       <= tickNext;
            addrReg       <= addrNext;
            activeClipReg <= activeClipNext;
            playClipReg   <= playClipNext;
            recordClipReg <= recordClipNext;
            clipValidReg  <= clipValidNext;
        end
    end

    // Next-state logic; the user reset button overrides every state.
    always_comb begin
        stateNext      = stateReg;
        tickNext       = tickReg;
        addrNext       = addrReg;
        activeClipNext = activeClipReg;
        playClipNext   = playClipReg;
        recordClipNext = recordClipReg;
        clipValidNext  = clipValidReg;
        if (resetButtonSync) begin
            stateNext      = IDLE;
            tickNext       = '0;
            addrNext       = '0;
            playClipNext   = 1'b0;
            recordClipNext = 1'b0;
            clipValidNext  = 2'b00;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (ClipNumPlaySync) begin
                        playClipNext = ~playClipReg;
                    end else begin
                        playClipNext = playClipReg;
                    end
                    if (ClipNumRecordSync) begin
                        recordClipNext = ~recordClipReg;
                    end else begin
                        recordClipNext = recordClipReg;
                    end
                    // Record has priority over a simultaneous play request.
                    if (RecordSync) begin
                        stateNext                    = RECORD;
                        activeClipNext               = recordClipReg;
                        clipValidNext[recordClipReg] = 1'b0;
                        addrNext                     = '0;
                        tickNext                     = '0;
                    end else if (PlaySync && clipValidReg[playClipReg]) begin
                        stateNext      = PLAY;
                        activeClipNext = playClipReg;
                        addrNext       = '0;
                        tickNext       = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                RECORD, PLAY: begin
                    if (tickReg == TICK_W'(TICK_DIV - 1)) begin
                        tickNext = '0;
                    end else begin
                        tickNext = tickReg + TICK_W'(1);
                    end
                    if (tickReg == '0) begin
                        if (lastAddr) begin
                            stateNext = IDLE;
                            addrNext  = '0;
                            tickNext  = '0;
                            if (stateReg == RECORD) begin
                                clipValidNext[activeClipReg] = 1'b1;
                            end else begin
                                clipValidNext = clipValidReg;
                            end
                        end else begin
                            addrNext = addrReg + ADDR_W'(1);
                        end
                    end else begin
                        addrNext = addrReg;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // Read-return path: data arrives the cycle after memRe and is then held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPendReg     <= 1'b0;
            heldSampleReg <= 8'h00;
        end else begin
            rdPendReg <= memRe;
            if (rdPendReg) begin
                heldSampleReg <= memRData;
            end else begin
                heldSampleReg <= heldSampleReg;
            end
        end
    end

    assign busy          = (stateReg != IDLE);
    assign memWe         = (stateReg == RECORD) && (tickReg == '0) && !resetButtonSync;
    assign memRe         = (stateReg == PLAY) && (tickReg == '0) && !resetButtonSync;
    assign memAddr       = busy ? {activeClipReg, addrReg} : '0;
    assign memWData      = memWe ? micSample : 8'h00;
    assign speakerValid  = rdPendReg;
    assign speakerSample = rdPendReg ? memRData : heldSampleReg;
    assign playClip      = playClipReg;
    assign recordClip    = recordClipReg;
    assign clipValid     = clipValidReg;

endmodule
